// File: rtl/rf_scan_reader_pkg.sv
// Shared types and default sizes for the register-file scan reader.
// The defaults match the 32x32 general-purpose register file this block reads.
package rf_scan_reader_pkg;

    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EMIT,
        DONE
    } scanState_t;

endpackage

// File: rtl/rf_scan_reader_if.sv
// Control, register-file read port and output stream of the scan reader.
// The master modport is the reader's side; the slave modport is the side of the surrounding logic.
interface rf_scan_reader_if
    import rf_scan_reader_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [AW:0]   count;

    modport master (
        input  start, abort, rf_data, out_ready,
        output busy, done, rf_addr, out_valid, out_addr, out_data, out_last, count
    );

    modport slave (
        output start, abort, rf_data, out_ready,
        input  busy, done, rf_addr, out_valid, out_addr, out_data, out_last, count
    );

endinterface

// File: rtl/rf_scan_reader.sv
// Walks register addresses 0..NREG-1 through one read port and streams (address, data) pairs out.
// Defining RF_SCAN_SKIP_ZERO_EN drops registers that read as zero from the stream.
module rf_scan_reader
    import rf_scan_reader_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    rf_scan_reader_if.master bus
);

`ifdef RF_SCAN_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

    scanState_t    state;
    logic [AW-1:0] index;
    logic          busyReg;
    logic          doneReg;
    logic          validReg;
    logic [AW-1:0] addrReg;
    logic [DW-1:0] dataReg;
    logic          lastReg;
    logic [AW:0]   countReg;

    // rf_addr follows the index, so it holds the last scanned address outside READ
    assign bus.rf_addr   = index;
    assign bus.busy      = busyReg;
    assign bus.done      = doneReg;
    assign bus.out_valid = validReg;
    assign bus.out_addr  = addrReg;
    assign bus.out_data  = dataReg;
    assign bus.out_last  = lastReg;
    assign bus.count     = countReg;

    // Abort outranks everything else while busy, including a handshake in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            index    <= '0;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
            validReg <= 1'b0;
            addrReg  <= '0;
            dataReg  <= '0;
            lastReg  <= 1'b0;
            countReg <= '0;
        end else if (state != IDLE && bus.abort) begin
            state    <= IDLE;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
            validReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state    <= READ;
                        busyReg  <= 1'b1;
                        index    <= '0;
                        countReg <= '0;
                    end
                end
                READ: begin
                    if (SKIP_ZERO && bus.rf_data == '0) begin
                        if (index == LAST_IDX) begin
                            state   <= DONE;
                            doneReg <= 1'b1;
                        end else begin
                            index <= index + IDX_ONE;
                        end
                    end else begin
                        dataReg  <= bus.rf_data;
                        addrReg  <= index;
                        lastReg  <= (index == LAST_IDX);
                        validReg <= 1'b1;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        validReg <= 1'b0;
                        countReg <= countReg + CNT_ONE;
                        if (index == LAST_IDX) begin
                            state   <= DONE;
                            doneReg <= 1'b1;
                        end else begin
                            index <= index + IDX_ONE;
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    doneReg <= 1'b0;
                    busyReg <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rf_scan_reader.md
# rf_scan_reader

Sequential reader for the 32×32 general-purpose register file. On a start pulse it walks register addresses 0..NREG-1 through one register-file read port and streams each (address, data) pair out over a valid/ready handshake. It is the debug and trace path, and it sits beside the datapath on a spare read port. Writes into the file are never issued by this block.

## Interface
Parameters:
- NREG, 32: number of registers scanned
- AW, 5: address width; must satisfy 2^AW ≥ NREG
- DW, 32: data width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a scan; sampled only in IDLE
- abort  in  1  terminate the scan in progress
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at normal scan completion
- rf_addr  out  AW  address driven to the register-file read port
- rf_data  in  DW  combinational read data for rf_addr
- out_valid  out  1  stream entry valid
- out_ready  in  1  downstream accepts the entry
- out_addr  out  AW  register index of the entry
- out_data  out  DW  register value of the entry
- out_last  out  1  high when out_addr == NREG-1
- count  out  AW+1  entries emitted in the current or last scan

## Operation
- FSM states: IDLE, READ, EMIT, DONE.
- IDLE → READ on start && !abort. Index is cleared to 0 and count is cleared to 0.
- READ:
  - rf_addr = index.
  - At the clock edge, rf_data is captured into out_data and index into out_addr.
  - Next state is EMIT, except in the skip case under Configuration.
- EMIT:
  - out_valid = 1. out_addr, out_data and out_last are held stable until handshake.
  - Handshake is out_valid && out_ready. On handshake, count increments.
  - After handshake: if index == NREG-1, go to DONE; otherwise index increments and the FSM goes to READ.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Abort in any non-IDLE state forces IDLE on the next edge. No done pulse. out_valid deasserts. count keeps its value.
- start while busy is ignored. start and abort together in IDLE: abort wins and the FSM stays in IDLE.
- Register 0 is scanned like any other register; its value is whatever the file returns (normally 0).
- rf_addr holds the last index outside READ. It is 0 after reset.

## Timing
- Reset values: busy 0, done 0, out_valid 0, out_addr 0, out_data 0, out_last 0, count 0, rf_addr 0, state IDLE.
- start at edge N: READ during cycle N+1; first out_valid in cycle N+2.
- Peak throughput is one entry per 2 cycles (READ + EMIT), with out_ready held high.
- A full unfiltered scan with out_ready held high: done pulses 2·NREG+1 cycles after the start edge.
- Back-pressure: EMIT may last any number of cycles. Outputs do not change while waiting.
- The register file updates on the falling edge. A value written in cycle k is therefore visible to a READ sampling at the rising edge ending cycle k.
- busy drops in the cycle after DONE.

## Configuration
- RF_SCAN_SKIP_ZERO_EN defined:
  - In READ, if rf_data == 0, no entry is emitted. If index < NREG-1, index increments and the FSM stays in READ; otherwise it goes to DONE.
  - Each skipped register costs one cycle.
  - count reflects only emitted entries. out_last appears only if register NREG-1 is nonzero.
- Undefined: every register is emitted and count ends at NREG.

## Structure
- Shared package holds:
  - FSM state enum: IDLE, READ, EMIT, DONE.
  - Constants: NREG, AW and DW defaults, shared with the register file.
- No sub-module. A single FSM plus an index counter.

## Test plan
- File preloaded with reg[i] = i·0x11, macro undefined, out_ready = 1, start pulse:
  - 32 entries in order; entry 5 is addr 5, data 0x55.
  - out_last only on addr 31; count = 32.
  - done at cycle 65 after start.
- Same preload, out_ready low for 3 cycles during entry 7: out_addr/out_data hold 7/0x77 stable; no entry is lost or duplicated.
- Macro defined, only reg 3 = 0xDEADBEEF and reg 31 = 1 nonzero: exactly 2 entries, (3, 0xDEADBEEF) then (31, 1) with out_last; count = 2.
- Macro defined, all registers zero: no out_valid; done pulses; count = 0.
- abort asserted while waiting in EMIT at addr 10: IDLE next cycle; out_valid 0; no done; count = 10.
- rst_n asserted mid-scan, then start together with abort in IDLE: all outputs return to reset values; the FSM stays in IDLE.
